// File: rtl/seg7_pkg.sv
// seg7_pkg: legal seven-segment digit patterns, tracker states and the error digit code
package seg7_pkg;
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [3:0] DIGIT_ERR = 4'hF;
   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: combinational seven-segment pattern to BCD digit decode with error flag
module seg7_lut
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] digit,
   output logic       err
);
   always_comb begin
      digit = pat == SEG_0 ? 4'd0 :
              pat == SEG_1 ? 4'd1 :
              pat == SEG_2 ? 4'd2 :
              pat == SEG_3 ? 4'd3 :
              pat == SEG_4 ? 4'd4 :
              pat == SEG_5 ? 4'd5 :
              pat == SEG_6 ? 4'd6 :
              pat == SEG_7 ? 4'd7 :
              pat == SEG_8 ? 4'd8 :
              pat == SEG_9 ? 4'd9 : DIGIT_ERR;
      err = digit == DIGIT_ERR;
   end
endmodule

// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader: debounces a seven-segment pattern and emits one decoded digit per stable run
module seg7_bcd_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic       seg_valid,
   input  logic       out_ready,
   input  logic       clr_overrun,
   output logic       out_valid,
   output logic [3:0] digit,
   output logic       err,
   output logic       overrun
);
   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
   state_t     state, state_n;
   logic [6:0] captured, captured_n;
   logic [3:0] count, count_n, lut_digit;
   logic       restart, emit, lut_err;
   // decode the pattern being captured/matched this cycle so the result registers with the final sample
   seg7_lut u_lut (.pat(captured_n), .digit(lut_digit), .err(lut_err));
   always_comb begin
      restart    = state == IDLE || seg != captured;
      count_n    = !seg_valid ? 4'd0 : restart ? 4'd1 : count == 4'hF ? count : count + 4'd1;
      captured_n = seg_valid && restart ? seg : captured;
      emit       = seg_valid && (restart || state == TRACK) && count_n == STABLE;
      state_n    = !seg_valid ? IDLE : emit || (state == LOCKED && !restart) ? LOCKED : TRACK;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= 4'd0;
         captured  <= 7'd0;
         out_valid <= 1'b0;
         digit     <= 4'd0;
         err       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         captured  <= captured_n;
         out_valid <= emit || (out_valid && !out_ready);
         overrun   <= (emit && out_valid && !out_ready) || (overrun && !clr_overrun);
         if (emit) begin
            digit <= lut_digit;
            err   <= lut_err;
         end
      end
   end
endmodule

// File: tb/tb_seg7_bcd_reader.sv
// tb_seg7_bcd_reader: directed vectors with hand-computed expectations for seg7_bcd_reader
module tb_seg7_bcd_reader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg = 7'h00;
   logic       seg_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       clr_overrun = 1'b0;
   logic       out_valid;
   logic [3:0] digit;
   logic       err;
   logic       overrun;
   int nvec = 0;
   int nerr = 0;
   int nres = 0;
   logic [3:0] last_digit = 4'd0;

   seg7_bcd_reader #(.STABLE_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .seg(seg), .seg_valid(seg_valid), .out_ready(out_ready),
      .clr_overrun(clr_overrun), .out_valid(out_valid), .digit(digit), .err(err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [6:0] s, input logic v);
      seg = s;
      seg_valid = v;
      @(posedge clk);
      #1;
      if (out_valid) begin
         nres++;
         last_digit = digit;
      end
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 8'(out_valid), 8'd0);
      chk("rst_digit", 8'(digit), 8'd0);
      chk("rst_err", 8'(err), 8'd0);
      chk("rst_overrun", 8'(overrun), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      // stable 5 with a single emission despite a long run
      step(7'h5B, 1'b1);
      chk("d5_s1_valid", 8'(out_valid), 8'd0);
      step(7'h5B, 1'b1);
      chk("d5_s2_valid", 8'(out_valid), 8'd0);
      step(7'h5B, 1'b1);
      chk("d5_valid", 8'(out_valid), 8'd1);
      chk("d5_digit", 8'(digit), 8'd5);
      chk("d5_err", 8'(err), 8'd0);
      nres = 0;
      for (int i = 0; i < 15; i++) step(7'h5B, 1'b1);
      chk("d5_single_pulse", 8'(nres), 8'd0);
      step(7'h00, 1'b0);
      // 30,30 then 7E x3: only a zero
      nres = 0;
      step(7'h30, 1'b1);
      step(7'h30, 1'b1);
      step(7'h7E, 1'b1);
      step(7'h7E, 1'b1);
      chk("d0_early", 8'(nres), 8'd0);
      step(7'h7E, 1'b1);
      chk("d0_count", 8'(nres), 8'd1);
      chk("d0_digit", 8'(last_digit), 8'd0);
      step(7'h00, 1'b0);
      // one invalid gap restarts counting
      nres = 0;
      step(7'h30, 1'b1);
      step(7'h30, 1'b1);
      step(7'h00, 1'b0);
      step(7'h30, 1'b1);
      step(7'h30, 1'b1);
      chk("gap_none_yet", 8'(nres), 8'd0);
      step(7'h30, 1'b1);
      chk("gap_count", 8'(nres), 8'd1);
      chk("gap_digit", 8'(last_digit), 8'd1);
      step(7'h00, 1'b0);
      // illegal pattern
      step(7'h00, 1'b1);
      step(7'h00, 1'b1);
      step(7'h00, 1'b1);
      chk("bad_valid", 8'(out_valid), 8'd1);
      chk("bad_digit", 8'(digit), 8'hF);
      chk("bad_err", 8'(err), 8'd1);
      step(7'h00, 1'b0);
      // backpressure and overrun
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(7'h79, 1'b1);
      chk("bp_d3_digit", 8'(digit), 8'd3);
      chk("bp_d3_overrun", 8'(overrun), 8'd0);
      for (int i = 0; i < 3; i++) step(7'h33, 1'b1);
      chk("bp_d4_digit", 8'(digit), 8'd4);
      chk("bp_d4_valid", 8'(out_valid), 8'd1);
      chk("bp_overrun", 8'(overrun), 8'd1);
      clr_overrun = 1'b1;
      step(7'h00, 1'b0);
      clr_overrun = 1'b0;
      chk("clr_overrun", 8'(overrun), 8'd0);
      chk("clr_hold_digit", 8'(digit), 8'd4);
      chk("clr_hold_valid", 8'(out_valid), 8'd1);
      out_ready = 1'b1;
      step(7'h00, 1'b0);
      chk("consume_valid", 8'(out_valid), 8'd0);
      // set beats clear on a simultaneous overwrite
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(7'h7E, 1'b1);
      step(7'h30, 1'b1);
      step(7'h30, 1'b1);
      clr_overrun = 1'b1;
      step(7'h30, 1'b1);
      clr_overrun = 1'b0;
      chk("setwins_overrun", 8'(overrun), 8'd1);
      chk("setwins_digit", 8'(digit), 8'd1);
      clr_overrun = 1'b1;
      step(7'h00, 1'b0);
      clr_overrun = 1'b0;
      chk("setwins_clr", 8'(overrun), 8'd0);
      // emit while the held result is consumed: no overrun
      step(7'h70, 1'b1);
      step(7'h70, 1'b1);
      out_ready = 1'b1;
      step(7'h70, 1'b1);
      chk("swap_valid", 8'(out_valid), 8'd1);
      chk("swap_digit", 8'(digit), 8'd7);
      chk("swap_overrun", 8'(overrun), 8'd0);
      step(7'h00, 1'b0);
      chk("swap_consumed", 8'(out_valid), 8'd0);
      // reset mid-track with an unconsumed result pending
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(7'h6D, 1'b1);
      step(7'h7F, 1'b1);
      step(7'h7F, 1'b1);
      chk("pre_rst_valid", 8'(out_valid), 8'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 8'(out_valid), 8'd0);
      chk("async_rst_digit", 8'(digit), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      step(7'h7F, 1'b1);
      chk("post_rst_s1", 8'(out_valid), 8'd0);
      step(7'h7F, 1'b1);
      chk("post_rst_s2", 8'(out_valid), 8'd0);
      step(7'h7F, 1'b1);
      chk("post_rst_valid", 8'(out_valid), 8'd1);
      chk("post_rst_digit", 8'(digit), 8'd8);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
